pipelined_multiplier: RTL and testbench
=======================================

Name: pipelined_multiplier

Overview:
- Fully pipelined unsigned shift-and-add multiplier.
- Complements the team's pipelined long divider: it rebuilds dividend = quotient*divisor (+ remainder externally) and serves as the general product path for card-pose and projection math.
- Accepts one operand pair per cycle with no stall.
- The result emerges a fixed number of cycles later with a matching valid strobe.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- REG_EVERY, 2, combinational partial-product stages between pipeline registers; WIDTH must be an integer multiple of REG_EVERY.

Ports:
- clk_in  input  1  system clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- multiplicand_in  input  WIDTH  unsigned operand A.
- multiplier_in  input  WIDTH  unsigned operand B.
- data_valid_in  input  1  operands valid this cycle.
- product_out  output  2*WIDTH  A*B, full width, no truncation.
- data_valid_out  output  1  product_out valid this cycle (one-cycle pulse per accepted input).
- busy_out  output  1  high while any valid operand is in flight in the pipeline.

Behaviour:
- Interface: one clock (clk_in); reset rst_in is asynchronous and active-high.
- Pipeline has WIDTH logical stages. Stage i (0..WIDTH-1) holds:
  - acc_i = acc_(i-1) + (B[i] ? (A << i) : 0), with acc_(-1) = 0 and 2*WIDTH-bit accumulation;
  - A and B carried alongside unchanged, and a valid bit.
- Register boundary after stage k when (k+1) mod REG_EVERY == 0; other stages are combinational.
- Latency L = WIDTH/REG_EVERY cycles, counted from the rising edge that samples data_valid_in=1 to data_valid_out=1. Defaults give L=16.
- Throughput: 1 result/cycle. Back-to-back inputs produce back-to-back outputs in order. There is no backpressure, so the consumer must accept every pulse.
- Invalid cycles are not dropped from the pipe; they travel as bubbles with valid=0.
  - Data registers still update, so product_out is don't-care when data_valid_out=0.
- busy_out = OR of all registered valid bits. Combinational from registers, no input term.
- Reset (asserted at any time, including mid-operation):
  - all valid bits clear immediately (async); data_valid_out=0, busy_out=0, product_out=0;
  - every in-flight operation is lost, with no partial output.
- First valid output after deassertion requires a new input and L cycles.
- Width rules:
  - product is exact for all inputs; max (2^W-1)^2 fits in 2*WIDTH bits;
  - partial sums never overflow because acc_i < 2^(WIDTH+i+1).
- Edge cases: A=0 or B=0 gives 0; A=1 gives B; data_valid_in held high continuously gives data_valid_out high continuously from cycle L onward.

Optional Feature:
- Macro MULT_OVERFLOW_EN.
- When defined:
  - extra output overflow_out (1 bit) is aligned with data_valid_out;
  - it is high when product_out[2*WIDTH-1:WIDTH] != 0, i.e. the result does not fit in WIDTH bits;
  - it is registered in the final stage (no added latency) and resets to 0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic: A=7, B=6, valid one cycle after reset release -> data_valid_out pulses exactly 16 cycles later with product_out=42; busy_out high for those 16 cycles then low.
- Max operands: A=B=0xFFFFFFFF -> product_out=0xFFFFFFFE00000001 (overflow_out=1 with MULT_OVERFLOW_EN); A=0x0000FFFF, B=0x00010000 -> 0x00000000FFFF0000 (overflow_out=0).
- Streaming: 20 consecutive valid pairs (A=i, B=i+3, i=0..19) -> 20 consecutive data_valid_out pulses starting at cycle 16, products i*(i+3) in order; a one-cycle input gap gives exactly one gap in the output.
- Zero/identity: (0, 0x12345678) -> 0; (1, 0xDEADBEEF) -> 0xDEADBEEF; (0x80000000, 2) -> 0x100000000.
- Reset mid-flight: inject 5 valid pairs, assert rst_in asynchronously between edges 8 cycles in -> data_valid_out, busy_out and product_out read 0 immediately; no stale pulses after release; the next input returns its correct product 16 cycles later.
- Parameter sweep: WIDTH=8, REG_EVERY=4 -> latency 2; exhaustive 256x256 products match a reference model.

Source files
------------

// File: rtl/pipelined_multiplier.sv
// Fully pipelined unsigned shift-and-add multiplier; one operand pair per cycle, latency WIDTH/REG_EVERY.
// Optional MULT_OVERFLOW_EN adds overflow_out, high when the product does not fit in WIDTH bits.
module pipelined_multiplier #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    input  logic                 data_valid_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 data_valid_out,
`ifdef MULT_OVERFLOW_EN
    output logic                 overflow_out,
`endif
    output logic                 busy_out
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned NSTG = WIDTH / REG_EVERY;

    logic [PW-1:0]    acc_q [NSTG];
    logic [PW-1:0]    acc_d [NSTG];
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] a_d   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];
    logic [WIDTH-1:0] b_d   [NSTG];
    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  vld_d;

    logic [PW-1:0]    src_acc [NSTG];
    logic [WIDTH-1:0] src_a   [NSTG];
    logic [WIDTH-1:0] src_b   [NSTG];
    logic [NSTG-1:0]  src_vld;

    // Register group 0 is fed by the ports; each later group reads its predecessor's registers.
    always_comb begin
        src_acc[0] = '0;
        src_a[0]   = multiplicand_in;
        src_b[0]   = multiplier_in;
        src_vld[0] = data_valid_in;
        for (int s = 1; s < int'(NSTG); s++) begin
            src_acc[s] = acc_q[s-1];
            src_a[s]   = a_q[s-1];
            src_b[s]   = b_q[s-1];
            src_vld[s] = vld_q[s-1];
        end
    end

    // Each register group folds REG_EVERY multiplier bits into the running sum.
    always_comb begin
        for (int s = 0; s < int'(NSTG); s++) begin
            acc_d[s] = src_acc[s];
            a_d[s]   = src_a[s];
            b_d[s]   = src_b[s];
            vld_d[s] = src_vld[s];
            for (int j = 0; j < int'(REG_EVERY); j++) begin
                if (src_b[s][s*int'(REG_EVERY)+j]) begin
                    acc_d[s] = acc_d[s] + (PW'(src_a[s]) << (s*int'(REG_EVERY)+j));
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q <= '0;
            for (int s = 0; s < int'(NSTG); s++) begin
                acc_q[s] <= '0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < int'(NSTG); s++) begin
                acc_q[s] <= acc_d[s];
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
            end
        end
    end

`ifdef MULT_OVERFLOW_EN
    logic ovf_q;
    logic ovf_d;

    // Flagged alongside the final accumulation so it lines up with data_valid_out.
    always_comb begin
        ovf_d = |acc_d[NSTG-1][PW-1:WIDTH];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_out = ovf_q;
`endif

    assign product_out    = acc_q[NSTG-1];
    assign data_valid_out = vld_q[NSTG-1];
    assign busy_out       = |vld_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed self-checking bench for pipelined_multiplier (default 32-bit build plus an 8-bit, REG_EVERY=4 instance).
module tb_pipelined_multiplier;

    localparam int unsigned W   = 32;
    localparam int unsigned RE  = 2;
    localparam int unsigned L   = W / RE;
    localparam int unsigned SW  = 8;
    localparam int unsigned SRE = 4;
    localparam int unsigned SL  = SW / SRE;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            vin;
    logic [2*W-1:0]  prod;
    logic            vout;
    logic            busy;
    logic            ovf;

    logic [SW-1:0]   sa;
    logic [SW-1:0]   sb;
    logic            svin;
    logic [2*SW-1:0] sprod;
    logic            svout;
    logic            sbusy;
    logic            sovf;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    pipelined_multiplier #(.WIDTH(W), .REG_EVERY(RE)) u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .multiplicand_in (a),
        .multiplier_in   (b),
        .data_valid_in   (vin),
        .product_out     (prod),
        .data_valid_out  (vout),
`ifdef MULT_OVERFLOW_EN
        .overflow_out    (ovf),
`endif
        .busy_out        (busy)
    );

    pipelined_multiplier #(.WIDTH(SW), .REG_EVERY(SRE)) u_small (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .multiplicand_in (sa),
        .multiplier_in   (sb),
        .data_valid_in   (svin),
        .product_out     (sprod),
        .data_valid_out  (svout),
`ifdef MULT_OVERFLOW_EN
        .overflow_out    (sovf),
`endif
        .busy_out        (sbusy)
    );

`ifndef MULT_OVERFLOW_EN
    assign ovf  = 1'b0;
    assign sovf = 1'b0;
`endif

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        vin = 1'b0; a = '0; b = '0;
        svin = 1'b0; sa = '0; sb = '0;
        #12;
        total++;
        if (vout !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", vout); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (prod !== 64'd0) begin bad++; $display("FAIL reset_product: got %h want 0", prod); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", ovf); end
        step();
        rst_in = 1'b0;
    endtask

    // Single operation on an empty pipe: exact latency, busy window, product and overflow.
    task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic [2*W-1:0] exp, input logic exp_ovf, input string name);
        a = ta; b = tb_; vin = 1'b1;
        for (int k = 1; k <= int'(L); k++) begin
            step();
            vin = 1'b0;
            total++;
            if (vout !== (k == int'(L))) begin
                bad++; $display("FAIL %s_valid cycle %0d: got %b want %b", name, k, vout, (k == int'(L)));
            end
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy cycle %0d: got %b want 1", name, k, busy); end
        end
        total++;
        if (prod !== exp) begin bad++; $display("FAIL %s_product: got %h want %h", name, prod, exp); end
`ifdef MULT_OVERFLOW_EN
        total++;
        if (ovf !== exp_ovf) begin bad++; $display("FAIL %s_overflow: got %b want %b", name, ovf, exp_ovf); end
`endif
        step();
        total++;
        if (vout !== 1'b0) begin bad++; $display("FAIL %s_valid_after: got %b want 0", name, vout); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_after: got %b want 0", name, busy); end
    endtask

    task automatic test_basic();
        run_one(32'd7, 32'd6, 64'd42, 1'b0, "basic");
    endtask

    task automatic test_max_operands();
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, "max");
        run_one(32'h0000_FFFF, 32'h0001_0000, 64'h0000_0000_FFFF_0000, 1'b0, "half");
    endtask

    task automatic test_zero_identity();
        run_one(32'd0, 32'h1234_5678, 64'd0, 1'b0, "zero");
        run_one(32'd1, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 1'b0, "identity");
        run_one(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1, "msb");
    endtask

    // Pair i is A=i, B=i+3; gap_at names the index sent with valid low (-1 for none).
    task automatic test_stream(input int n, input int gap_at, input string name);
        for (int e = 1; e <= n + int'(L) + 2; e++) begin
            int i;
            int src;
            logic exp_v;
            logic [2*W-1:0] exp_p;
            i = e - 1;
            if (i < n) begin
                vin = (i != gap_at); a = W'(i); b = W'(i + 3);
            end else begin
                vin = 1'b0;
            end
            step();
            src   = e - int'(L);
            exp_v = (src >= 0) && (src < n) && (src != gap_at);
            exp_p = 64'(src) * 64'(src + 3);
            total++;
            if (vout !== exp_v) begin bad++; $display("FAIL %s_valid edge %0d: got %b want %b", name, e, vout, exp_v); end
            if (exp_v) begin
                total++;
                if (prod !== exp_p) begin bad++; $display("FAIL %s_product idx %0d: got %h want %h", name, src, prod, exp_p); end
            end
        end
        vin = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_stream(20, -1, "stream");
        test_stream(10, 5, "gap");
    endtask

    task automatic test_reset_midflight();
        for (int e = 1; e <= 5; e++) begin
            a = W'(e + 10); b = W'(e + 20); vin = 1'b1;
            step();
        end
        vin = 1'b0;
        step(); step(); step();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midflight_busy_before: got %b want 1", busy); end
        #2;
        rst_in = 1'b1;
        #1;
        total++;
        if (vout !== 1'b0) begin bad++; $display("FAIL midflight_valid: got %b want 0", vout); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midflight_busy: got %b want 0", busy); end
        total++;
        if (prod !== 64'd0) begin bad++; $display("FAIL midflight_product: got %h want 0", prod); end
        step(); step();
        rst_in = 1'b0;
        for (int k = 1; k <= int'(L) + 2; k++) begin
            step();
            total++;
            if (vout !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL midflight_stale cycle %0d: got valid=%b busy=%b want 0 0", k, vout, busy);
            end
        end
        run_one(32'd3, 32'd5, 64'd15, 1'b0, "after_reset");
    endtask

    // Streams all 65536 8-bit pairs back to back; output after edge e belongs to pair e-SL.
    task automatic test_small_exhaustive();
        int n;
        n = 1 << (2 * SW);
        for (int e = 1; e <= n + int'(SL) + 1; e++) begin
            int i;
            int src;
            logic exp_v;
            logic [2*SW-1:0] exp_p;
            logic [15:0] pair;
            i = e - 1;
            if (i < n) begin
                pair = 16'(i);
                svin = 1'b1; sa = pair[15:8]; sb = pair[7:0];
            end else begin
                svin = 1'b0;
            end
            step();
            src   = e - int'(SL);
            exp_v = (src >= 0) && (src < n);
            pair  = 16'(src);
            exp_p = 16'(pair[15:8]) * 16'(pair[7:0]);
            total++;
            if (svout !== exp_v) begin bad++; $display("FAIL small_valid edge %0d: got %b want %b", e, svout, exp_v); end
            if (exp_v) begin
                total++;
                if (sprod !== exp_p) begin
                    bad++; $display("FAIL small_product %0d*%0d: got %h want %h", pair[15:8], pair[7:0], sprod, exp_p);
                end
            end
        end
        svin = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_operands();
        test_zero_identity();
        test_back_to_back();
        test_reset_midflight();
        test_small_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
